// File: rtl/ps2_mouse_tx.sv
// Device-side PS/2 transmitter: byte FIFO feeding an 11-bit frame serializer
// that drives emulated ps2_clk/ps2_data, advancing only on the 2x bit-rate tick.
module ps2_mouse_tx #(
    parameter int AW        = 3,
    parameter int GAP_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       inhibit,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       ps2_clk,
    output logic       ps2_data
);
    localparam int DEPTH = 2 ** AW;
    localparam int GW    = $clog2(GAP_TICKS + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    state_t          state_q, state_d;
    logic [10:0]     sreg_q, sreg_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            clk_q, clk_d;
    logic            data_q, data_d;
    logic            ovf_q, ovf_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      head;
    logic            push, pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign push  = wr && !full;

    assign busy     = (state_q == HIGH) || (state_q == LOW);
    assign overflow = ovf_q;
    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        ovf_d    = ovf_q | (wr & full);
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_d     = gap_q;
        clk_d     = clk_q;
        data_d    = data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && !empty && !inhibit) begin
                    sreg_d    = {1'b1, ~^head, head, 1'b0};
                    bit_cnt_d = 4'd0;
                    data_d    = 1'b0;
                    clk_d     = 1'b1;
                    state_d   = HIGH;
                end
            end
            HIGH, LOW: begin
                // Inhibit aborts immediately; the byte stays at the FIFO head.
                if (inhibit) begin
                    clk_d   = 1'b1;
                    data_d  = 1'b1;
                    gap_d   = GW'(GAP_TICKS);
                    state_d = GAP;
                end else if (tick && state_q == HIGH) begin
                    clk_d   = 1'b0;
                    state_d = LOW;
                end else if (tick) begin
                    clk_d = 1'b1;
                    if (bit_cnt_q == 4'd10) begin
                        data_d  = 1'b1;
                        pop     = 1'b1;
                        gap_d   = GW'(GAP_TICKS);
                        state_d = GAP;
                    end else begin
                        sreg_d    = {1'b1, sreg_q[10:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        data_d    = sreg_q[1];
                        state_d   = HIGH;
                    end
                end
            end
            GAP: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (tick) begin
                    if (gap_q <= GW'(1)) begin
                        gap_d   = '0;
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sreg_q    <= '1;
            bit_cnt_q <= '0;
            gap_q     <= '0;
            clk_q     <= 1'b1;
            data_q    <= 1'b1;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_q     <= gap_d;
            clk_q     <= clk_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: doc/ps2_mouse_tx.md
Name: ps2_mouse_tx

Overview:
- Device-side PS/2 transmitter that serializes queued mouse packet bytes onto emulated ps2_clk/ps2_data lines.
- It is the sending end of the link whose receiving end is the ps2_mouse decoder in the top level.
- Used to inject mouse movement/button packets generated from host input into the BK core's mouse receiver.
- Includes a small byte FIFO, frame state machine, odd-parity generation, inter-frame gap timer and host-inhibit handling.

Parameters:
- AW, 3, FIFO address width; depth = 2**AW bytes.
- GAP_TICKS, 8, idle tick count between the end of one frame and the start of the next (min 1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- tick  input  1  one-cycle strobe at 2x PS/2 bit rate (e.g. ~28 kHz); all line activity advances only on tick.
- wr  input  1  write strobe, pushes din into FIFO.
- din  input  8  byte to transmit.
- inhibit  input  1  host inhibit; high blocks/aborts transmission.
- full  output  1  FIFO full.
- empty  output  1  FIFO empty.
- busy  output  1  frame in progress (state not IDLE/GAP).
- overflow  output  1  sticky: a write arrived while full.
- ps2_clk  output  1  emulated PS/2 clock, idle high.
- ps2_data  output  1  emulated PS/2 data, idle high.

Behaviour:
- Reset (sync, active-high; clock clk): FIFO emptied (full=0, empty=1), overflow=0, busy=0, ps2_clk=1, ps2_data=1, state=IDLE, gap counter=0.
- FIFO:
  - Push on wr when !full.
  - wr while full drops the byte and sets overflow until reset.
  - Simultaneous push and pop in one clk are both honoured.
  - Pointers wrap modulo 2**AW; full/empty are derived from an extra pointer bit.
  - The head byte is popped only after its stop bit completes. Aborted bytes stay at the head.
- Frame: 11 bits = start 0, d[0]..d[7] LSB first, odd parity (~^d), stop 1.
- Each bit is 2 ticks:
  - On the first tick, ps2_data is updated to the bit value and ps2_clk=1.
  - On the second tick, ps2_clk=0 (the receiver samples on the falling edge).
  - ps2_data never changes while ps2_clk=0.
- Frame length is 22 ticks. After the stop-bit low phase, the next tick sets ps2_clk=1 and ps2_data=1.
- States:
  - IDLE: on tick with !empty && !inhibit → load shift register {1, parity, head byte, 0}, bit counter=0, enter HIGH. Drive ps2_data=0, ps2_clk=1, busy=1.
  - HIGH: on tick → ps2_clk=0, enter LOW.
  - LOW, on tick:
    - If bit counter==10 → ps2_clk=1, ps2_data=1, pop FIFO, load gap counter=GAP_TICKS, enter GAP, busy=0.
    - Else → shift, counter+1, ps2_data=next bit, ps2_clk=1, enter HIGH.
  - GAP: gap counter decrements on tick; at 0 → IDLE. Lines stay high.
- Inhibit:
  - Sampled every clk.
  - Asserted in HIGH/LOW: next clk forces ps2_clk=1, ps2_data=1, abort to GAP with GAP_TICKS, no pop, busy=0. The frame restarts from the start bit after inhibit drops and the gap expires.
  - Asserted in IDLE/GAP: blocks frame start only.
- Between ticks, all outputs hold. Throughput is one frame per 22+GAP_TICKS+1 ticks.

Test Plan:
- Single byte 0x08, inhibit=0, GAP_TICKS=8:
  - Data at successive ps2_clk falling edges = 0,0,0,0,1,0,0,0,0,0,1 (parity 0).
  - Exactly 11 falling edges in 22 ticks; busy high for 22 ticks; empty=1 after the stop bit.
- Byte 0x00: parity bit = 1. Byte 0xFF: parity bit = 1. Byte 0x03: parity bit = 1. Byte 0x01: parity bit = 0. Check against a bench PS/2 receiver model (ps2_mouse decoder).
- 3-byte packet 0x09,0x05,0xFB written back-to-back:
  - Three frames received in order.
  - Each inter-frame gap is at least 9 ticks with both lines high.
- inhibit=1, write 9 bytes (0x10..0x18):
  - full=1 after the 8th write; 0x18 dropped; overflow=1.
  - Release inhibit → 0x10..0x17 transmitted; overflow remains 1 until reset.
- Inhibit mid-frame: assert inhibit after the 4th falling edge of byte 0xA5.
  - Lines go high within 1 clk; busy=0.
  - Release inhibit → full 0xA5 frame resent from the start bit; receiver sees exactly one 0xA5.
- Reset mid-frame (after the 6th bit):
  - Next clk: ps2_clk=1, ps2_data=1, empty=1, overflow=0.
  - No further edges until a new write.
